// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared widths and source encodings for the EXU write-back arbiter slice.
package e203_exu_wbck_arb_pkg;
    localparam int XLEN    = 32;  // tracks E203_XLEN
    localparam int RFIDX_W = 5;   // tracks E203_RFIDX_WIDTH
    localparam int ITAG_W  = 2;   // tracks E203_ITAG_WIDTH
    localparam int CNT_W   = 4;   // starvation counter width

    localparam logic SRC_ALU   = 1'b0;
    localparam logic SRC_LONGP = 1'b1;
endpackage

// File: rtl/e203_wbck_outreg.sv
// Single-entry valid/ready write-back output register.
// i_ready doubles as the load enable: the entry can be refilled in the
// same cycle it drains, so a continuous stream sees no bubbles.
module e203_wbck_outreg
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int DW = XLEN,
    parameter int IW = RFIDX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_wdat,
    input  logic [IW-1:0] i_rdidx,
    input  logic          i_src,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_wdat,
    output logic [IW-1:0] o_rdidx,
    output logic          o_src
);
    logic          valid_q, valid_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic [IW-1:0] rdidx_q, rdidx_d;
    logic          src_q, src_d;

    assign i_ready = ~valid_q | o_ready;

    // Next entry: hold while stalled, otherwise take the push (or go empty).
    always_comb begin
        valid_d = valid_q;
        wdat_d  = wdat_q;
        rdidx_d = rdidx_q;
        src_d   = src_q;
        if (i_ready) begin
            valid_d = i_valid;
            if (i_valid) begin
                wdat_d  = i_wdat;
                rdidx_d = i_rdidx;
                src_d   = i_src;
            end
        end
    end

    // Entry register; reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wdat_q  <= '0;
            rdidx_q <= '0;
            src_q   <= SRC_ALU;
        end else begin
            valid_q <= valid_d;
            wdat_q  <= wdat_d;
            rdidx_q <= rdidx_d;
            src_q   <= src_d;
        end
    end

    assign o_valid = valid_q;
    assign o_wdat  = wdat_q;
    assign o_rdidx = rdidx_q;
    assign o_src   = src_q;
endmodule

// File: rtl/e203_exu_wbck_arb.sv
// EXU write-back arbiter: ALU vs. long-pipe onto the single regfile port.
// Long-pipe may only write back the OITF head entry; its grant retires it.
// Build option E203_WBCK_ARB_RR_EN swaps the starvation counter for a
// 1-bit round-robin pointer.
module e203_exu_wbck_arb
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4   // 1..15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_wbck_i_valid,
    output logic               alu_wbck_i_ready,
    input  logic [XLEN-1:0]    alu_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
    input  logic               longp_wbck_i_valid,
    output logic               longp_wbck_i_ready,
    input  logic [XLEN-1:0]    longp_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
    input  logic [ITAG_W-1:0]  longp_wbck_i_itag,
    input  logic               oitf_empty,
    input  logic [ITAG_W-1:0]  oitf_ret_ptr,
    output logic               oitf_ret_ena,
    output logic               rf_wbck_o_valid,
    input  logic               rf_wbck_o_ready,
    output logic [XLEN-1:0]    rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
    output logic               rf_wbck_o_src
);
    logic               ld, alu_elig, lp_elig, alu_win;
    logic               gnt_alu, gnt_lp, push;
    logic [XLEN-1:0]    sel_wdat;
    logic [RFIDX_W-1:0] sel_rdidx;

    assign alu_elig = alu_wbck_i_valid;
    assign lp_elig  = longp_wbck_i_valid & ~oitf_empty
                    & (longp_wbck_i_itag == oitf_ret_ptr);

`ifdef E203_WBCK_ARB_RR_EN
    logic ptr_q, ptr_d;

    // Contention goes to the pointed-to source (0 = ALU); lone requester wins.
    always_comb begin
        alu_win = alu_elig & (~lp_elig | (ptr_q == SRC_ALU));
        ptr_d   = ptr_q ^ (gnt_alu | gnt_lp);
    end

    // Round-robin pointer, flips after every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= SRC_ALU;
        else     ptr_q <= ptr_d;
    end
`else
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // ALU has priority until the head long-pipe entry has been passed over
    // STARVE_MAX times; count only moves on cycles the output can load.
    always_comb begin
        alu_win      = alu_elig & (starve_cnt_q < STARVE_LIM);
        starve_cnt_d = starve_cnt_q;
        if (ld) begin
            if (gnt_lp | ~lp_elig)
                starve_cnt_d = '0;
            else if (starve_cnt_q < STARVE_LIM)
                starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`endif

    // Grants only when the output can take an entry; silenced during reset.
    always_comb begin
        gnt_alu   = ~rst & ld & alu_win;
        gnt_lp    = ~rst & ld & lp_elig & ~alu_win;
        sel_wdat  = gnt_lp ? longp_wbck_i_wdat  : alu_wbck_i_wdat;
        sel_rdidx = gnt_lp ? longp_wbck_i_rdidx : alu_wbck_i_rdidx;
        // x0 writes complete the handshake but never reach the regfile.
        push      = (gnt_alu | gnt_lp) & (sel_rdidx != '0);
    end

    assign alu_wbck_i_ready   = gnt_alu;
    assign longp_wbck_i_ready = gnt_lp;
    assign oitf_ret_ena       = gnt_lp;

    e203_wbck_outreg #(.DW(XLEN), .IW(RFIDX_W)) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .i_valid (push),
        .i_ready (ld),
        .i_wdat  (sel_wdat),
        .i_rdidx (sel_rdidx),
        .i_src   (gnt_lp ? SRC_LONGP : SRC_ALU),
        .o_valid (rf_wbck_o_valid),
        .o_ready (rf_wbck_o_ready),
        .o_wdat  (rf_wbck_o_wdat),
        .o_rdidx (rf_wbck_o_rdidx),
        .o_src   (rf_wbck_o_src)
    );
endmodule
